// File: rtl/bcd_counter_2d.sv
// Two-digit packed-BCD up/down counter stepped by an internal prescaler.
// Q[3:0] is the ones digit, Q[7:4] the tens digit; Tick/Carry are registered step pulses.
module bcd_counter_2d #(
    parameter int CLK_HZ  = 50000000,
    parameter int STEP_HZ = 1
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       En,
    input  logic       Up,
    input  logic       Load,
    input  logic [7:0] D,
    output logic [7:0] Q,
    output logic       Tick,
    output logic       Carry
);
    localparam int             DIV       = CLK_HZ / STEP_HZ;
    localparam int             PW        = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);

    logic [PW-1:0] r_presc;
    logic [3:0]    r_ones;
    logic [3:0]    r_tens;
    logic          r_tick;
    logic          r_carry;

    logic [3:0]    w_ones_nx;
    logic [3:0]    w_tens_nx;
    logic          w_wrap;
    logic          w_step;

    function automatic logic [3:0] bcd_clip(input logic [3:0] d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

    assign w_step = En && !Load && (r_presc == PRESC_MAX);

    // Value Q would take if a step happened now, in the direction Up selects.
    always_comb begin
        w_ones_nx = r_ones;
        w_tens_nx = r_tens;
        w_wrap    = 1'b0;
        if (Up) begin
            if (r_ones == 4'd9) begin
                w_ones_nx = 4'd0;
                if (r_tens == 4'd9) begin
                    w_tens_nx = 4'd0;
                    w_wrap    = 1'b1;
                end else begin
                    w_tens_nx = r_tens + 4'd1;
                end
            end else begin
                w_ones_nx = r_ones + 4'd1;
            end
        end else begin
            if (r_ones == 4'd0) begin
                w_ones_nx = 4'd9;
                if (r_tens == 4'd0) begin
                    w_tens_nx = 4'd9;
                    w_wrap    = 1'b1;
                end else begin
                    w_tens_nx = r_tens - 4'd1;
                end
            end else begin
                w_ones_nx = r_ones - 4'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_presc <= '0;
            r_ones  <= 4'd0;
            r_tens  <= 4'd0;
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
        end else if (Load) begin
            // Non-decimal switch digits are forced to zero so Q stays valid BCD.
            r_presc <= '0;
            r_ones  <= bcd_clip(D[3:0]);
            r_tens  <= bcd_clip(D[7:4]);
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_tick  <= w_step;
            r_carry <= w_step && w_wrap;
            if (w_step) begin
                r_presc <= '0;
                r_ones  <= w_ones_nx;
                r_tens  <= w_tens_nx;
            end else if (En) begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign Q     = {r_tens, r_ones};
    assign Tick  = r_tick;
    assign Carry = r_carry;
endmodule

// File: tb/tb_bcd_counter_2d.sv
// Directed bench for bcd_counter_2d with DIV = 4; expected values are written out by hand.
module tb_bcd_counter_2d;
    logic       Clock;
    logic       Resetn;
    logic       En;
    logic       Up;
    logic       Load;
    logic [7:0] D;
    logic [7:0] Q;
    logic       Tick;
    logic       Carry;

    int vectors    = 0;
    int miscompares = 0;

    bcd_counter_2d #(.CLK_HZ(4), .STEP_HZ(1)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .En    (En),
        .Up    (Up),
        .Load  (Load),
        .D     (D),
        .Q     (Q),
        .Tick  (Tick),
        .Carry (Carry)
    );

    // clock / reset
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // one rising edge, then settle 1 time unit before anything is sampled or driven
    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] q, input logic t, input logic c);
        chk({tag, ".q"}, Q, q);
        chk({tag, ".tick"}, {7'd0, Tick}, {7'd0, t});
        chk({tag, ".carry"}, {7'd0, Carry}, {7'd0, c});
    endtask

    // driver: one-edge load strobe
    task automatic do_load(input logic [7:0] d);
        Load = 1'b1;
        D    = d;
        cyc();
        Load = 1'b0;
    endtask

    // four edges from prescaler 0: three quiet cycles holding prev, then the step
    task automatic step_wait(input string tag, input logic [7:0] prev, input logic [7:0] q,
                             input logic c);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_out({tag, ".wait"}, prev, 1'b0, 1'b0);
        end
        cyc();
        chk_out({tag, ".step"}, q, 1'b1, c);
    endtask

    logic [7:0] exp_q[$];

    initial begin
        Resetn = 1'b0;
        En     = 1'b0;
        Up     = 1'b1;
        Load   = 1'b0;
        D      = 8'h00;
        cyc();
        cyc();
        chk_out("reset", 8'h00, 1'b0, 1'b0);

        // free-running count from reset: one step every 4 edges
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10};
        En     = 1'b1;
        Up     = 1'b1;
        Resetn = 1'b1;
        begin
            logic [7:0] cur;
            cur = 8'h00;
            for (int k = 1; k <= 40; k++) begin
                cyc();
                if (k % 4 == 0) begin
                    cur = exp_q.pop_front();
                    chk_out("run", cur, 1'b1, 1'b0);
                end else begin
                    chk_out("run", cur, 1'b0, 1'b0);
                end
            end
        end

        // up wrap 98 -> 99 -> 00 -> 01
        do_load(8'h98);
        chk_out("ld98", 8'h98, 1'b0, 1'b0);
        step_wait("up99", 8'h98, 8'h99, 1'b0);
        step_wait("up00", 8'h99, 8'h00, 1'b1);
        step_wait("up01", 8'h00, 8'h01, 1'b0);

        // down wrap 01 -> 00 -> 99 -> 98
        Up = 1'b0;
        do_load(8'h01);
        chk_out("ld01", 8'h01, 1'b0, 1'b0);
        step_wait("dn00", 8'h01, 8'h00, 1'b0);
        step_wait("dn99", 8'h00, 8'h99, 1'b1);
        step_wait("dn98", 8'h99, 8'h98, 1'b0);

        // non-decimal digits load as zero
        do_load(8'hAF);
        chk_out("ldAF", 8'h00, 1'b0, 1'b0);
        do_load(8'h5B);
        chk_out("ld5B", 8'h50, 1'b0, 1'b0);

        // load on a step-condition cycle wins, prescaler restarts
        Up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_out("pre", 8'h50, 1'b0, 1'b0);
        end
        do_load(8'h27);
        chk_out("ldstep", 8'h27, 1'b0, 1'b0);
        step_wait("st28", 8'h27, 8'h28, 1'b0);

        // freeze with prescaler at 2, then resume from 2
        cyc();
        cyc();
        chk_out("pre2", 8'h28, 1'b0, 1'b0);
        En = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_out("frozen", 8'h28, 1'b0, 1'b0);
            if (i == 4) Up = 1'b0;
        end
        En = 1'b1;
        cyc();
        chk_out("resume1", 8'h28, 1'b0, 1'b0);
        Up = 1'b1;
        cyc();
        chk_out("resume2", 8'h29, 1'b1, 1'b0);

        // Up flips away from the step edge have no effect
        cyc();
        Up = 1'b0;
        cyc();
        Up = 1'b1;
        cyc();
        cyc();
        chk_out("upflip", 8'h30, 1'b1, 1'b0);

        // asynchronous reset between edges with Q=47 and prescaler at 2
        do_load(8'h46);
        step_wait("st47", 8'h46, 8'h47, 1'b0);
        cyc();
        cyc();
        #2;
        Resetn = 1'b0;
        #1;
        chk_out("async", 8'h00, 1'b0, 1'b0);
        #2;
        cyc();
        chk_out("rsthold", 8'h00, 1'b0, 1'b0);
        Resetn = 1'b1;
        step_wait("rst01", 8'h00, 8'h01, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
